// File: rtl/axi_addr_issue.sv
// AXI AR/AW address issuer: pops burst descriptors, splits them at 4 KB boundaries,
// issues INCR bursts and logs one tracking record per burst for out-of-order completion.
`timescale 1ns / 1ps

module axi_addr_issue #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned ID_W    = 6,
    parameter int unsigned META_W  = 12,
    parameter int unsigned MAX_OUT = 16,
    parameter int unsigned CNT_W   = $clog2(MAX_OUT) + 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [META_W+3+8+ID_W+ADDR_W-1:0]   desc_rddata,
    input  logic                                desc_empty,
    output logic                                desc_rd,
    output logic [ID_W-1:0]                     axi_axid,
    output logic [ADDR_W-1:0]                   axi_axaddr,
    output logic [7:0]                          axi_axlen,
    output logic [2:0]                          axi_axsize,
    output logic [1:0]                          axi_axburst,
    output logic                                axi_axvalid,
    input  logic                                axi_axready,
    input  logic                                transfifo_full,
    output logic                                transfifo_wr,
    output logic [META_W+1+ID_W+3+8+ADDR_W-1:0] transfifo_wrdata,
    input  logic                                rsp_done,
    output logic [CNT_W-1:0]                    outstanding,
    output logic                                busy,
    output logic                                err_misalign
);

    localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {StIdle, StLoad, StIssue} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, axaddr_q;
    logic [8:0]          rem_q;
    logic [ID_W-1:0]     id_q;
    logic [2:0]          size_q;
    logic [META_W-1:0]   meta_q;
    logic [7:0]          axlen_q;
    logic                last_q, axvalid_q, axvalid_d, err_q;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;

    logic [ADDR_W-1:0]   d_addr;
    logic [ID_W-1:0]     d_id;
    logic [7:0]          d_len;
    logic [2:0]          d_size;
    logic [META_W-1:0]   d_meta;

    assign d_addr = desc_rddata[ADDR_W-1:0];
    assign d_id   = desc_rddata[ADDR_W +: ID_W];
    assign d_len  = desc_rddata[ADDR_W+ID_W +: 8];
    assign d_size = desc_rddata[ADDR_W+ID_W+8 +: 3];
    assign d_meta = desc_rddata[ADDR_W+ID_W+11 +: META_W];

    logic [12:0]       bnd_beats;
    logic [8:0]        chunk, issued;
    logic [ADDR_W-1:0] addr_step;
    logic [6:0]        size_mask;
    logic              misalign, can_issue, handshake, capture;

    // Beats left before the next 4 KB page; never zero for an aligned address.
    assign bnd_beats = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> size_q;
    assign chunk     = ({4'd0, rem_q} < bnd_beats) ? rem_q : bnd_beats[8:0];
    assign issued    = {1'b0, axlen_q} + 9'd1;
    assign addr_step = {{(ADDR_W-9){1'b0}}, issued} << size_q;
    assign size_mask = (7'd1 << d_size) - 7'd1;
    assign misalign  = |(d_addr[6:0] & size_mask);
    assign can_issue = !transfifo_full && (outstanding_q < MaxOut);
    assign handshake = axvalid_q & axi_axready;
    assign capture   = (state_q == StIdle) && !desc_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        axvalid_d = axvalid_q;
        unique case (state_q)
            StIdle: begin
                if (!desc_empty) state_d = StLoad;
            end
            StLoad: begin
                state_d   = StIssue;
                axvalid_d = can_issue;
            end
            StIssue: begin
                if (handshake) begin
                    axvalid_d = 1'b0;
                    state_d   = last_q ? StIdle : StLoad;
                end else if (!axvalid_q) begin
                    axvalid_d = can_issue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        desc_rd          = capture;
        transfifo_wr     = handshake;
        busy             = (state_q != StIdle) | axvalid_q;
        axi_axvalid      = axvalid_q;
        axi_axid         = id_q;
        axi_axaddr       = axaddr_q;
        axi_axlen        = axlen_q;
        axi_axsize       = size_q;
        axi_axburst      = 2'b01;
        transfifo_wrdata = {meta_q, last_q, id_q, size_q, axlen_q, axaddr_q};
        outstanding      = outstanding_q;
        err_misalign     = err_q;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (handshake && !rsp_done) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!handshake && rsp_done && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr_q    <= '0;
            rem_q         <= '0;
            id_q          <= '0;
            size_q        <= '0;
            meta_q        <= '0;
            axaddr_q      <= '0;
            axlen_q       <= '0;
            last_q        <= 1'b0;
            axvalid_q     <= 1'b0;
            err_q         <= 1'b0;
            outstanding_q <= '0;
        end else begin
            axvalid_q     <= axvalid_d;
            outstanding_q <= outstanding_d;
            if (capture) begin
                cur_addr_q <= d_addr;
                rem_q      <= {1'b0, d_len} + 9'd1;
                id_q       <= d_id;
                size_q     <= d_size;
                meta_q     <= d_meta;
                err_q      <= err_q | misalign;
            end
            if (state_q == StLoad) begin
                axaddr_q <= cur_addr_q;
                axlen_q  <= 8'(chunk - 9'd1);
                last_q   <= (chunk == rem_q);
            end
            if (handshake) begin
                cur_addr_q <= cur_addr_q + addr_step;
                rem_q      <= rem_q - issued;
            end
        end
    end

endmodule

// File: tb/tb_axi_addr_issue.sv
// Bench for axi_addr_issue: directed descriptors feed a FIFO model, expected burst records
// go into a queue, and a monitor checks every transfifo write against that queue.
`timescale 1ns / 1ps

module tb_axi_addr_issue;

    localparam int ADDR_W = 64;
    localparam int ID_W   = 6;
    localparam int META_W = 12;
    localparam int DESC_W = META_W + 3 + 8 + ID_W + ADDR_W;
    localparam int REC_W  = META_W + 1 + ID_W + 3 + 8 + ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DESC_W-1:0] desc_rddata = '0;
    logic              desc_empty = 1'b1;
    logic              desc_rd;
    logic [ID_W-1:0]   axi_axid;
    logic [ADDR_W-1:0] axi_axaddr;
    logic [7:0]        axi_axlen;
    logic [2:0]        axi_axsize;
    logic [1:0]        axi_axburst;
    logic              axi_axvalid;
    logic              axi_axready = 1'b1;
    logic              transfifo_full = 1'b0;
    logic              transfifo_wr;
    logic [REC_W-1:0]  transfifo_wrdata;
    logic              rsp_done = 1'b0;
    logic [4:0]        outstanding;
    logic              busy;
    logic              err_misalign;

    axi_addr_issue dut (
        .clk              (clk),
        .reset            (reset),
        .desc_rddata      (desc_rddata),
        .desc_empty       (desc_empty),
        .desc_rd          (desc_rd),
        .axi_axid         (axi_axid),
        .axi_axaddr       (axi_axaddr),
        .axi_axlen        (axi_axlen),
        .axi_axsize       (axi_axsize),
        .axi_axburst      (axi_axburst),
        .axi_axvalid      (axi_axvalid),
        .axi_axready      (axi_axready),
        .transfifo_full   (transfifo_full),
        .transfifo_wr     (transfifo_wr),
        .transfifo_wrdata (transfifo_wrdata),
        .rsp_done         (rsp_done),
        .outstanding      (outstanding),
        .busy             (busy),
        .err_misalign     (err_misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cnt   = 0;
    logic [DESC_W-1:0] dq[$];
    logic [REC_W-1:0]  exp_q[$];
    logic pop_pend = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [DESC_W-1:0] mk_desc(input logic [63:0] a, input logic [7:0] len,
                                                  input logic [2:0] sz, input logic [5:0] id,
                                                  input logic [11:0] meta);
        return {meta, sz, len, id, a};
    endfunction

    function automatic logic [REC_W-1:0] mk_rec(input logic [63:0] a, input logic [7:0] len,
                                                input logic [2:0] sz, input logic [5:0] id,
                                                input logic [11:0] meta, input logic last);
        return {meta, last, id, sz, len, a};
    endfunction

    // Descriptor FIFO model: first-word-fall-through, updated away from the rising edge.
    always @(posedge clk) begin
        if (!reset && desc_rd) pop_pend = 1'b1;
    end

    always @(negedge clk) begin
        logic [DESC_W-1:0] tmp;
        if (pop_pend) begin
            tmp = dq.pop_front();
            pop_pend = 1'b0;
        end
        desc_empty  = (dq.size() == 0);
        desc_rddata = desc_empty ? '0 : dq[0];
    end

    // Monitor: every accepted burst must match the next expected record.
    always @(negedge clk) begin
        logic [REC_W-1:0] r;
        if (!reset && transfifo_wr) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", transfifo_wrdata, '0);
            end else begin
                r = exp_q.pop_front();
                chk("rec", transfifo_wrdata, r);
                chk("axaddr", axi_axaddr, r[63:0]);
                chk("axlen", axi_axlen, r[71:64]);
                chk("axsize", axi_axsize, r[74:72]);
                chk("axid", axi_axid, r[80:75]);
                chk("axburst", axi_axburst, 2'b01);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((dq.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        chk("wait_idle_in_time", (n < 300), 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!axi_axvalid && n < 50) begin
            tick();
            n++;
        end
        chk("wait_valid_in_time", (n < 50), 1);
    endtask

    task automatic drain(input int n);
        rsp_done = 1'b1;
        repeat (n) tick();
        rsp_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int bad;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_desc_rd", desc_rd, 0);
        chk("rst_axvalid", axi_axvalid, 0);
        chk("rst_wr", transfifo_wr, 0);
        chk("rst_payload", {axi_axid, axi_axaddr, axi_axlen, axi_axsize}, '0);
        chk("rst_axburst", axi_axburst, 2'b01);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_misalign, 0);
        reset = 1'b0;
        tick();

        // Single aligned burst with latency checks
        dq.push_back(mk_desc(64'h1000, 8'd3, 3'd3, 6'd5, 12'hABC));
        exp_q.push_back(mk_rec(64'h1000, 8'd3, 3'd3, 6'd5, 12'hABC, 1'b1));
        @(negedge clk);
        #1;
        chk("t1_desc_rd", desc_rd, 1);
        tick();
        chk("t1_load_novalid", axi_axvalid, 0);
        chk("t1_rd_single", desc_rd, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_valid_n2", axi_axvalid, 1);
        tick();
        chk("t1_valid_drop", axi_axvalid, 0);
        chk("t1_out1", outstanding, 1);
        chk("t1_idle", busy, 0);
        drain(1);
        chk("t1_out0", outstanding, 0);

        // 4 KB split into two bursts
        dq.push_back(mk_desc(64'h0F80, 8'd31, 3'd3, 6'd9, 12'h123));
        exp_q.push_back(mk_rec(64'h0F80, 8'd15, 3'd3, 6'd9, 12'h123, 1'b0));
        exp_q.push_back(mk_rec(64'h1000, 8'd15, 3'd3, 6'd9, 12'h123, 1'b1));
        wait_idle();
        chk("t2_out2", outstanding, 2);
        drain(2);

        // 16 KB burst across several pages
        dq.push_back(mk_desc(64'h0800, 8'd255, 3'd6, 6'd3, 12'h777));
        exp_q.push_back(mk_rec(64'h0800, 8'd31, 3'd6, 6'd3, 12'h777, 1'b0));
        exp_q.push_back(mk_rec(64'h1000, 8'd63, 3'd6, 6'd3, 12'h777, 1'b0));
        exp_q.push_back(mk_rec(64'h2000, 8'd63, 3'd6, 6'd3, 12'h777, 1'b0));
        exp_q.push_back(mk_rec(64'h3000, 8'd63, 3'd6, 6'd3, 12'h777, 1'b0));
        exp_q.push_back(mk_rec(64'h4000, 8'd31, 3'd6, 6'd3, 12'h777, 1'b1));
        wait_idle();
        chk("t3_out5", outstanding, 5);
        drain(5);
        chk("t3_out0", outstanding, 0);

        // Backpressure: full blocks raising, then stall on axready with full toggling
        transfifo_full = 1'b1;
        axi_axready = 1'b0;
        dq.push_back(mk_desc(64'h2000, 8'd7, 3'd2, 6'd1, 12'h055));
        exp_q.push_back(mk_rec(64'h2000, 8'd7, 3'd2, 6'd1, 12'h055, 1'b1));
        repeat (6) tick();
        chk("t4_full_blocks", axi_axvalid, 0);
        chk("t4_busy", busy, 1);
        transfifo_full = 1'b0;
        wait_valid();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) transfifo_full = 1'b1;
            if (i == 7) transfifo_full = 1'b0;
            tick();
            if (!axi_axvalid || axi_axaddr != 64'h2000 || axi_axlen != 8'd7 ||
                axi_axid != 6'd1 || transfifo_wr) bad++;
        end
        chk("t4_stable_cycles_bad", bad, 0);
        hs0 = hs_cnt;
        axi_axready = 1'b1;
        wait_idle();
        chk("t4_one_wr", hs_cnt - hs0, 1);
        chk("t4_out1", outstanding, 1);
        drain(1);
        chk("t4_out0", outstanding, 0);

        // Outstanding limit
        for (int i = 0; i < 20; i++) begin
            dq.push_back(mk_desc(64'h10000 + 64'(i) * 64'h100, 8'd0, 3'd3, 6'(i), 12'(i)));
            exp_q.push_back(mk_rec(64'h10000 + 64'(i) * 64'h100, 8'd0, 3'd3, 6'(i), 12'(i), 1'b1));
        end
        hs0 = hs_cnt;
        repeat (120) tick();
        chk("t5_hs16", hs_cnt - hs0, 16);
        chk("t5_out16", outstanding, 16);
        chk("t5_valid_low", axi_axvalid, 0);
        drain(1);
        chk("t5_out15", outstanding, 15);
        chk("t5_valid_still_low", axi_axvalid, 0);
        tick();
        chk("t5_valid17", axi_axvalid, 1);
        chk("t5_addr17", axi_axaddr, 64'h11000);
        drain(1);
        chk("t5_simul_out15", outstanding, 15);
        chk("t5_hs17", hs_cnt - hs0, 17);
        repeat (10) tick();
        chk("t5_hs18", hs_cnt - hs0, 18);
        chk("t5_out16_again", outstanding, 16);
        drain(40);
        wait_idle();
        chk("t5_hs20", hs_cnt - hs0, 20);
        chk("t5_out0", outstanding, 0);

        // Misaligned descriptor sets sticky error
        chk("t6_err_clear", err_misalign, 0);
        dq.push_back(mk_desc(64'h1004, 8'd0, 3'd3, 6'd2, 12'h0AA));
        exp_q.push_back(mk_rec(64'h1004, 8'd0, 3'd3, 6'd2, 12'h0AA, 1'b1));
        wait_idle();
        chk("t6_err_set", err_misalign, 1);
        repeat (3) tick();
        chk("t6_err_sticky", err_misalign, 1);
        chk("t6_out1", outstanding, 1);

        // Asynchronous reset while axvalid is high
        axi_axready = 1'b0;
        dq.push_back(mk_desc(64'h3000, 8'd0, 3'd3, 6'd7, 12'h001));
        wait_valid();
        hs0 = hs_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk("t7_axvalid", axi_axvalid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_out", outstanding, 0);
        chk("t7_err", err_misalign, 0);
        chk("t7_payload", {axi_axid, axi_axaddr, axi_axlen, axi_axsize}, '0);
        chk("t7_desc_rd", desc_rd, 0);
        axi_axready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("t7_no_hs", hs_cnt - hs0, 0);
        chk("t7_valid_low", axi_axvalid, 0);
        chk("t7_out_after", outstanding, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
